player_input_ctrl: RTL and testbench

- Upstream conditioning stage for one player's movement block.
- Takes raw, asynchronous board buttons and synchronises and debounces each one.
- Samples them on the per-frame update strobe and delivers frame-stable right/left/jump/squat/defend levels.
- Owns two policies: single-frame jump-press conversion, and the defend duration/cooldown state machine. The movement block therefore sees clean, rule-compliant commands.

---
 rtl/player_input_ctrl_pkg.sv | 26 ++
 rtl/player_input_ctrl_btn_debounce.sv | 47 ++++
 rtl/player_input_ctrl.sv | 117 +++++++++++
 tb/tb_player_input_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/player_input_ctrl_pkg.sv
`default_nettype none
// ============================================================
// player_input_ctrl_pkg: shared game constants, button indices and
// defend state encoding.                              Rev 1.0
// ============================================================
package player_input_ctrl_pkg;

  localparam int DEFEND_MAX_FR = 30;
  localparam int DEFEND_CD_FR  = 60;

  localparam int NUM_BTN    = 5;
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_DEFEND = 4;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_ACTIVE  = 2'd1,
    D_COOL    = 2'd2,
    D_WAITREL = 2'd3
  } defend_state_e;

endpackage
`default_nettype wire

// File: rtl/player_input_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================
// btn_debounce: two-flop synchroniser plus hold-time debounce filter,
// with a one-cycle pulse on each debounced rising edge.  Rev 1.0
// ============================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int DB_W         = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  import player_input_ctrl_pkg::*;

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        // s2 has differed for DEBOUNCE_CYC consecutive cycles
        level <= s2;
        rise  <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/player_input_ctrl.sv
`default_nettype none
// ============================================================
// player_input_ctrl: debounced, frame-sampled player buttons with
// single-frame jump and defend duration/cooldown policy. Rev 1.0
// ============================================================
module player_input_ctrl #(
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int DEFEND_MAX_FR = player_input_ctrl_pkg::DEFEND_MAX_FR,
  parameter int DEFEND_CD_FR  = player_input_ctrl_pkg::DEFEND_CD_FR,
  parameter int DB_W          = $clog2(DEBOUNCE_CYC + 1),
  parameter int FR_W          = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_jump,
  input  logic btn_squat,
  input  logic btn_defend,
  output logic right,
  output logic left,
  output logic jump,
  output logic squat,
  output logic defend,
  output logic defend_cd
);
  import player_input_ctrl_pkg::*;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic               unused_rise;
  logic               jump_pend;
  defend_state_e      state;
  logic [FR_W-1:0]    cnt;

  assign raw = {btn_defend, btn_squat, btn_jump, btn_left, btn_right};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .DB_W        (DB_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // Only jump is edge-driven; the other buttons are consumed as levels.
  assign unused_rise = ^{rise[BTN_RIGHT], rise[BTN_LEFT], rise[BTN_SQUAT], rise[BTN_DEFEND]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right     <= 1'b0;
      left      <= 1'b0;
      squat     <= 1'b0;
      jump      <= 1'b0;
      jump_pend <= 1'b0;
    end else if (frame_tick) begin
      right     <= level[BTN_RIGHT] & ~level[BTN_LEFT];
      left      <= level[BTN_LEFT] & ~level[BTN_RIGHT];
      squat     <= level[BTN_SQUAT];
      jump      <= jump_pend;
      jump_pend <= rise[BTN_JUMP];  // an edge coincident with the tick waits for the next one
    end else if (rise[BTN_JUMP]) begin
      jump_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= D_IDLE;
      cnt       <= '0;
      defend    <= 1'b0;
      defend_cd <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        D_IDLE: begin
          if (level[BTN_DEFEND]) begin
            state  <= D_ACTIVE;
            defend <= 1'b1;
            cnt    <= FR_W'(1);
          end
        end
        D_ACTIVE: begin
          if (!level[BTN_DEFEND] || cnt == FR_W'(DEFEND_MAX_FR)) begin
            state     <= D_COOL;
            defend    <= 1'b0;
            defend_cd <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        D_COOL: begin
          if (cnt == FR_W'(DEFEND_CD_FR - 1)) begin
            cnt       <= '0;
            defend_cd <= 1'b0;
            state     <= level[BTN_DEFEND] ? D_WAITREL : D_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        D_WAITREL: begin
          if (!level[BTN_DEFEND]) state <= D_IDLE;
        end
        default: state <= D_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_input_ctrl.sv
`default_nettype none
// tb_player_input_ctrl: directed and randomized button stimulus scored
// against a frame-level reference model of the input rules.
module tb_player_input_ctrl;
  localparam int DEBOUNCE_CYC = 4;
  localparam int MAX_FR       = 5;
  localparam int CD_FR        = 3;
  localparam int FRAME        = 20;
  localparam int HL           = DEBOUNCE_CYC + 2;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       frame_tick = 1'b0;
  logic [4:0] btn        = '0;
  logic       right, left, jump, squat, defend, defend_cd;

  player_input_ctrl #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .DEFEND_MAX_FR(MAX_FR),
    .DEFEND_CD_FR (CD_FR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .btn_right (btn[0]),
    .btn_left  (btn[1]),
    .btn_jump  (btn[2]),
    .btn_squat (btn[3]),
    .btn_defend(btn[4]),
    .right     (right),
    .left      (left),
    .jump      (jump),
    .squat     (squat),
    .defend    (defend),
    .defend_cd (defend_cd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame strobe: one cycle in FRAME, or every cycle while tick_cont is set
  int tick_div  = 0;
  bit tick_cont = 1'b0;
  initial forever begin
    @(negedge clk);
    if (tick_cont) begin
      frame_tick = 1'b1;
    end else begin
      frame_tick = (tick_div == FRAME - 1);
      tick_div   = (tick_div == FRAME - 1) ? 0 : tick_div + 1;
    end
  end

  // Reference model: debounced level flips once the raw button has shown the
  // opposite value for DEBOUNCE_CYC consecutive samples, seen 2 clk late.
  typedef struct packed {logic r, l, j, s, d, cd;} outs_t;
  outs_t      exp_q[$];
  logic [4:0] hist[HL];
  logic [4:0] lvl      = '0;
  logic [4:0] lvl_prev = '0;
  bit         pend     = 1'b0;
  int         act_fr   = 0;
  int         cool_left = 0;
  bit         need_rel = 1'b0;
  outs_t      cur_exp  = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      for (int k = 0; k < HL; k++) hist[k] = '0;
      lvl = '0; lvl_prev = '0; pend = 1'b0;
      act_fr = 0; cool_left = 0; need_rel = 1'b0; cur_exp = '0;
    end else begin
      logic [4:0] rise_v;
      logic       dd;
      bit         flip;
      rise_v = lvl & ~lvl_prev;
      dd     = lvl[4];
      if (frame_tick) begin
        cur_exp.r = lvl[0] & ~lvl[1];
        cur_exp.l = lvl[1] & ~lvl[0];
        cur_exp.s = lvl[3];
        cur_exp.j = pend;
        pend      = rise_v[2];
        if (cool_left > 0) begin
          cool_left--;
          cur_exp.cd = (cool_left > 0);
          if (cool_left == 0) need_rel = dd;
        end else if (act_fr > 0) begin
          if (!dd || act_fr == MAX_FR) begin
            act_fr = 0; cur_exp.d = 1'b0; cur_exp.cd = 1'b1; cool_left = CD_FR;
          end else begin
            act_fr++;
          end
        end else if (need_rel) begin
          if (!dd) need_rel = 1'b0;
        end else if (dd) begin
          act_fr = 1; cur_exp.d = 1'b1;
        end
        exp_q.push_back(cur_exp);
      end else if (rise_v[2]) begin
        pend = 1'b1;
      end
      for (int k = 0; k < HL - 1; k++) hist[k] = hist[k+1];
      hist[HL-1] = btn;
      lvl_prev = lvl;
      for (int b = 0; b < 5; b++) begin
        flip = 1'b1;
        for (int k = 0; k < DEBOUNCE_CYC; k++) if (hist[k][b] == lvl[b]) flip = 1'b0;
        if (flip) lvl[b] = ~lvl[b];
      end
    end
  end

  // Monitor: consume one expectation per frame tick, hold it between ticks
  outs_t last = '0;
  int n_right = 0, n_left = 0, n_jump = 0, n_squat = 0, n_def = 0, n_cd = 0;
  initial forever begin
    logic  tk;
    outs_t got;
    @(posedge clk);
    tk = frame_tick;
    #1;
    if (!rst_n) begin
      last = '0;
    end else begin
      got = {right, left, jump, squat, defend, defend_cd};
      if (tk) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 0, 1);
        else last = exp_q.pop_front();
        n_right += int'(got.r); n_left += int'(got.l); n_jump += int'(got.j);
        n_squat += int'(got.s); n_def  += int'(got.d); n_cd   += int'(got.cd);
      end
      check(tk ? "outputs_at_tick" : "outputs_hold", int'(got), int'(last));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (frame_tick !== 1'b1 && k < 100) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 100) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int s_j, s_s, s_r, s_l, s_d, s_c, k;
    rst_n = 1'b0;
    cyc(3);
    check("reset_outputs", int'({right, left, jump, squat, defend, defend_cd}), 0);
    rst_n = 1'b1;
    cyc(10);

    // Squat glitch, then a 10-clk press aligned so a tick lands inside it
    wait_tick(); cyc(5);
    s_s = n_squat; btn[3] = 1'b1; cyc(3); btn[3] = 1'b0; cyc(45);
    check("squat_glitch_frames", n_squat - s_s, 0);
    wait_tick(); cyc(10);
    s_s = n_squat; btn[3] = 1'b1; cyc(10); btn[3] = 1'b0; cyc(40);
    check("squat_held_frames", n_squat - s_s, 1);

    // Jump: long hold, re-press, short press
    s_j = n_jump; btn[2] = 1'b1; cyc(200); btn[2] = 1'b0; cyc(60);
    check("jump_hold_frames", n_jump - s_j, 1);
    s_j = n_jump; btn[2] = 1'b1; cyc(100); btn[2] = 1'b0; cyc(60);
    check("jump_repress_frames", n_jump - s_j, 1);
    wait_tick(); cyc(2);
    s_j = n_jump; btn[2] = 1'b1; cyc(8); btn[2] = 1'b0; cyc(60);
    check("jump_short_press_frames", n_jump - s_j, 1);

    // Direction conflict
    s_r = n_right; s_l = n_left; btn[1:0] = 2'b11; cyc(60);
    check("conflict_right_frames", n_right - s_r, 0);
    btn[1] = 1'b0; cyc(60);
    check("conflict_left_frames", n_left - s_l, 0);
    check("right_after_left_release", int'(n_right > s_r), 1);
    btn[0] = 1'b0; cyc(40);

    // Defend expiry while held, then re-arm after release
    s_d = n_def; s_c = n_cd; btn[4] = 1'b1; cyc(400);
    check("defend_expiry_frames", n_def - s_d, MAX_FR);
    check("defend_expiry_cd_frames", n_cd - s_c, CD_FR);
    btn[4] = 1'b0; cyc(60);
    s_d = n_def; btn[4] = 1'b1; cyc(100); btn[4] = 1'b0; cyc(40);
    check("defend_rearm", int'(n_def > s_d), 1);
    cyc(140);

    // Early release, then a press during cooldown still held at its end
    wait_tick();
    s_d = n_def; s_c = n_cd;
    btn[4] = 1'b1; cyc(40); btn[4] = 1'b0; cyc(30); btn[4] = 1'b1; cyc(80);
    check("early_release_defend_frames", n_def - s_d, 2);
    check("early_release_cd_frames", n_cd - s_c, CD_FR);
    btn[4] = 1'b0; cyc(80);

    // Reset while defending with a jump pending
    btn[4] = 1'b1; k = 0;
    while (defend !== 1'b1 && k < 100) begin cyc(1); k++; end
    check("defend_before_reset", int'(defend), 1);
    wait_tick(); btn[2] = 1'b1; cyc(10);
    rst_n = 1'b0; btn[2] = 1'b0; #1;
    check("reset_mid_outputs", int'({right, left, jump, squat, defend, defend_cd}), 0);
    cyc(3); rst_n = 1'b1;
    wait_tick(); @(posedge clk); #1;
    check("jump_after_reset", int'(jump), 0);
    cyc(40);
    check("defend_after_reset", int'(defend), 1);
    btn[4] = 1'b0; cyc(200);

    // Randomized buttons, including short glitches and a run of back-to-back ticks
    for (int i = 0; i < 150; i++) begin
      btn = 5'($urandom);
      cyc($urandom_range(1, 60));
    end
    tick_cont = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btn = 5'($urandom);
      cyc($urandom_range(2, 10));
    end
    tick_cont = 1'b0;
    btn = '0;
    cyc(300);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
